sprite_mover: RTL and testbench



---
 rtl/sprite_pkg.sv | 48 ++++
 rtl/sprite_mover_tick_sync.sv | 28 ++
 rtl/sprite_mover.sv | 154 +++++++++++++++
 tb/tb_sprite_mover.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the keyboard-driven sprite mover.
// Holds the direction/state enums, WASD keycodes and small decode helpers.
package sprite_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        LEFT  = 3'd1,
        RIGHT = 3'd2,
        UP    = 3'd3,
        DOWN  = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOVING  = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;

    function automatic dir_t decode_key(input logic [7:0] code);
        dir_t d;
        case (code)
            KEY_A:   d = LEFT;
            KEY_D:   d = RIGHT;
            KEY_W:   d = UP;
            KEY_S:   d = DOWN;
            default: d = NONE;
        endcase
        return d;
    endfunction

    function automatic dir_t reverse_dir(input dir_t d);
        dir_t r;
        case (d)
            LEFT:    r = RIGHT;
            RIGHT:   r = LEFT;
            UP:      r = DOWN;
            DOWN:    r = UP;
            default: r = NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sprite_mover_tick_sync.sv
// Brings the asynchronous frame strobe into the Clk domain and turns each
// rising edge into a single registered one-Clk tick.
module tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic sync_a;
    logic sync_b;
    logic sync_prev;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            sync_a    <= 1'b0;
            sync_b    <= 1'b0;
            sync_prev <= 1'b0;
            tick      <= 1'b0;
        end else begin
            sync_a    <= frame_clk;
            sync_b    <= sync_a;
            sync_prev <= sync_b;
            tick      <= sync_b & ~sync_prev;
        end
    end

endmodule

// File: rtl/sprite_mover.sv
// Sprite motion controller: buffers a WASD direction and advances the sprite
// once per frame tick, stopping or bouncing at the play-field walls.
module sprite_mover
    import sprite_pkg::*;
#(
    parameter int W         = 10,
    parameter int NUM_KEYS  = 2,
    parameter int X_CENTER  = 320,
    parameter int Y_CENTER  = 240,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 639,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 479,
    parameter int SIZE      = 4,
    parameter int STEP      = 1,
    parameter int WALL_MODE = 0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_clk,
    input  logic                  enable,
    input  logic [8*NUM_KEYS-1:0] keycodes,
    output logic [W-1:0]          PosX,
    output logic [W-1:0]          PosY,
    output logic [W-1:0]          SizeOut,
    output logic [2:0]            Dir,
    output logic                  Moving,
    output logic                  HitWall
);

    localparam logic signed [W+1:0] X_LO   = (W+2)'(X_MIN + SIZE);
    localparam logic signed [W+1:0] X_HI   = (W+2)'(X_MAX - SIZE);
    localparam logic signed [W+1:0] Y_LO   = (W+2)'(Y_MIN + SIZE);
    localparam logic signed [W+1:0] Y_HI   = (W+2)'(Y_MAX - SIZE);
    localparam logic signed [W+1:0] STEP_S = (W+2)'(STEP);

    logic   tick;
    logic   [W-1:0] pos_x;
    logic   [W-1:0] pos_y;
    dir_t   dir_q;
    dir_t   pend_q;
    state_t state_q;
    logic   moving_q;
    logic   hit_q;

    dir_t   key_dir;
    dir_t   eff_dir;
    dir_t   new_dir;
    logic   blocked;
    logic   hit;
    logic signed [W+1:0] cx;
    logic signed [W+1:0] cy;
    logic signed [W+1:0] nx;
    logic signed [W+1:0] ny;

    tick_sync u_tick_sync (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    // Scan from the top slot down so the lowest-index direction key wins.
    always_comb begin
        key_dir = NONE;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (decode_key(keycodes[8*k +: 8]) != NONE)
                key_dir = decode_key(keycodes[8*k +: 8]);
        end
    end

    // A key present on the tick cycle overrides the buffered one, so the
    // motion applied always reflects the freshest request.
    always_comb begin
        eff_dir = (key_dir != NONE) ? key_dir : pend_q;
        cx      = $signed({2'b00, pos_x});
        cy      = $signed({2'b00, pos_y});

        case (eff_dir)
            LEFT:    blocked = (cx == X_LO);
            RIGHT:   blocked = (cx == X_HI);
            UP:      blocked = (cy == Y_LO);
            DOWN:    blocked = (cy == Y_HI);
            default: blocked = 1'b1;
        endcase
        new_dir = blocked ? dir_q : eff_dir;

        nx = cx;
        ny = cy;
        case (new_dir)
            LEFT:    nx = cx - STEP_S;
            RIGHT:   nx = cx + STEP_S;
            UP:      ny = cy - STEP_S;
            DOWN:    ny = cy + STEP_S;
            default: ;
        endcase
        if (nx < X_LO) nx = X_LO;
        if (nx > X_HI) nx = X_HI;
        if (ny < Y_LO) ny = Y_LO;
        if (ny > Y_HI) ny = Y_HI;

        hit = ((new_dir == LEFT)  && (nx == X_LO)) ||
              ((new_dir == RIGHT) && (nx == X_HI)) ||
              ((new_dir == UP)    && (ny == Y_LO)) ||
              ((new_dir == DOWN)  && (ny == Y_HI));
    end

    // Motion FSM; the tick consumes the pending request even when it is
    // discarded because it points into the wall.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pos_x    <= W'(X_CENTER);
            pos_y    <= W'(Y_CENTER);
            dir_q    <= NONE;
            pend_q   <= NONE;
            state_q  <= IDLE;
            moving_q <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            hit_q <= 1'b0;
            if (key_dir != NONE)
                pend_q <= key_dir;
            if (tick && enable) begin
                pend_q <= NONE;
                pos_x  <= nx[W-1:0];
                pos_y  <= ny[W-1:0];
                hit_q  <= hit;
                if (hit) begin
                    if (WALL_MODE == 0) begin
                        dir_q    <= NONE;
                        state_q  <= BLOCKED;
                        moving_q <= 1'b0;
                    end else begin
                        dir_q    <= reverse_dir(new_dir);
                        state_q  <= MOVING;
                        moving_q <= 1'b1;
                    end
                end else if (new_dir != NONE) begin
                    dir_q    <= new_dir;
                    state_q  <= MOVING;
                    moving_q <= 1'b1;
                end
            end
        end
    end

    assign PosX    = pos_x;
    assign PosY    = pos_y;
    assign SizeOut = W'(SIZE);
    assign Dir     = dir_q;
    assign Moving  = moving_q;
    assign HitWall = hit_q;

endmodule

// File: tb/tb_sprite_mover.sv
// Table-driven scoreboard bench for sprite_mover: a stop-mode instance walks
// the main sequence, a bounce-mode instance covers the clamped bounce.
module tb_sprite_mover;

    logic        Clk;
    logic        Reset;
    logic        Reset1;
    logic        frame_clk;
    logic        enable;
    logic [15:0] keycodes;
    logic [15:0] keys1;

    logic [9:0]  PosX, PosY, SizeOut;
    logic [2:0]  Dir;
    logic        Moving, HitWall;
    logic [9:0]  PosX1, PosY1, SizeOut1;
    logic [2:0]  Dir1;
    logic        Moving1, HitWall1;

    int errors = 0;
    int checks = 0;
    logic hit_at_tick, hit_after_tick, hit1_at_tick;

    typedef struct {
        logic [7:0] slot1;
        logic [7:0] slot0;
        bit         at_tick;
        logic       en;
        int         ticks;
        int         exp_x;
        int         exp_y;
        int         exp_dir;
        int         exp_mov;
        int         exp_hit;
    } vec_t;

    vec_t vecs[16];
    vec_t sb[$];

    sprite_mover dut_a (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .enable(enable),
        .keycodes(keycodes), .PosX(PosX), .PosY(PosY), .SizeOut(SizeOut),
        .Dir(Dir), .Moving(Moving), .HitWall(HitWall)
    );

    sprite_mover #(.STEP(3), .WALL_MODE(1)) dut_b (
        .Clk(Clk), .Reset(Reset1), .frame_clk(frame_clk), .enable(enable),
        .keycodes(keys1), .PosX(PosX1), .PosY(PosY1), .SizeOut(SizeOut1),
        .Dir(Dir1), .Moving(Moving1), .HitWall(HitWall1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One frame strobe; optionally a key is held only on the tick cycle.
    task automatic doTick(input logic [15:0] key_at, input bit use_key);
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        if (use_key) keycodes = key_at;
        @(negedge Clk);
        hit_at_tick  = HitWall;
        hit1_at_tick = HitWall1;
        if (use_key) keycodes = 16'h0000;
        frame_clk = 1'b0;
        @(negedge Clk);
        hit_after_tick = HitWall;
        repeat (2) @(negedge Clk);
    endtask

    task automatic applyStimulus(input vec_t v);
        sb.push_back(v);
        enable = v.en;
        if (!v.at_tick) begin
            keycodes = {v.slot1, v.slot0};
            @(negedge Clk);
            keycodes = 16'h0000;
        end
        for (int t = 0; t < v.ticks; t++)
            doTick({v.slot1, v.slot0}, v.at_tick);
    endtask

    initial begin
        vec_t e;
        Reset = 1'b0; Reset1 = 1'b0; frame_clk = 1'b0; enable = 1'b1;
        keycodes = 16'h0000; keys1 = 16'h0000;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        checkOutput("reset_posx", int'(PosX), 320);
        checkOutput("reset_posy", int'(PosY), 240);
        checkOutput("reset_dir", int'(Dir), 0);
        checkOutput("reset_moving", int'(Moving), 0);
        checkOutput("reset_hit", int'(HitWall), 0);
        checkOutput("size_out", int'(SizeOut), 4);

        //           slot1  slot0  atT en tk   x    y   dir mov hit
        vecs[0]  = '{8'h00, 8'h00, 0, 1, 5,   320, 240, 0, 0, 0};
        vecs[1]  = '{8'h00, 8'h07, 0, 1, 1,   321, 240, 2, 1, 0};
        vecs[2]  = '{8'h00, 8'h00, 0, 1, 1,   322, 240, 2, 1, 0};
        vecs[3]  = '{8'h00, 8'h00, 0, 1, 1,   323, 240, 2, 1, 0};
        vecs[4]  = '{8'h00, 8'h00, 0, 1, 311, 634, 240, 2, 1, 0};
        vecs[5]  = '{8'h00, 8'h00, 0, 1, 1,   635, 240, 0, 0, 1};
        vecs[6]  = '{8'h00, 8'h07, 0, 1, 1,   635, 240, 0, 0, 0};
        vecs[7]  = '{8'h00, 8'h04, 0, 1, 1,   634, 240, 1, 1, 0};
        vecs[8]  = '{8'h04, 8'h1A, 0, 1, 1,   634, 239, 3, 1, 0};
        vecs[9]  = '{8'h1A, 8'h04, 0, 1, 1,   633, 239, 1, 1, 0};
        vecs[10] = '{8'h07, 8'h05, 0, 1, 1,   634, 239, 2, 1, 0};
        vecs[11] = '{8'h00, 8'h16, 1, 1, 1,   634, 240, 4, 1, 0};
        vecs[12] = '{8'h00, 8'h00, 0, 1, 1,   634, 241, 4, 1, 0};
        vecs[13] = '{8'h00, 8'h04, 0, 0, 3,   634, 241, 4, 1, 0};
        vecs[14] = '{8'h00, 8'h00, 0, 1, 1,   633, 241, 1, 1, 0};
        vecs[15] = '{8'h00, 8'h00, 0, 1, 233, 400, 241, 1, 1, 0};

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            e = sb.pop_front();
            checkOutput($sformatf("v%0d_posx", i), int'(PosX), e.exp_x);
            checkOutput($sformatf("v%0d_posy", i), int'(PosY), e.exp_y);
            checkOutput($sformatf("v%0d_dir", i), int'(Dir), e.exp_dir);
            checkOutput($sformatf("v%0d_moving", i), int'(Moving), e.exp_mov);
            checkOutput($sformatf("v%0d_hit", i), int'(hit_at_tick), e.exp_hit);
            checkOutput($sformatf("v%0d_hit_pulse", i), int'(hit_after_tick), 0);
        end

        // Reset mid-motion, with a key held during reset that must not stick.
        keycodes = 16'h0007;
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        keycodes = 16'h0000;
        checkOutput("midreset_posx", int'(PosX), 320);
        checkOutput("midreset_posy", int'(PosY), 240);
        checkOutput("midreset_dir", int'(Dir), 0);
        checkOutput("midreset_moving", int'(Moving), 0);
        doTick(16'h0000, 1'b0);
        checkOutput("postreset_posx", int'(PosX), 320);
        checkOutput("postreset_dir", int'(Dir), 0);

        // Bounce mode with STEP=3: walk up to Y=6, clamp to 4, bounce to 7.
        Reset1 = 1'b1;
        @(negedge Clk);
        keys1 = 16'h001A;
        @(negedge Clk);
        keys1 = 16'h0000;
        for (int t = 0; t < 78; t++) doTick(16'h0000, 1'b0);
        checkOutput("bounce_pre_posy", int'(PosY1), 6);
        checkOutput("bounce_pre_posx", int'(PosX1), 320);
        checkOutput("bounce_pre_dir", int'(Dir1), 3);
        doTick(16'h0000, 1'b0);
        checkOutput("bounce_clamp_posy", int'(PosY1), 4);
        checkOutput("bounce_clamp_hit", int'(hit1_at_tick), 1);
        checkOutput("bounce_clamp_dir", int'(Dir1), 4);
        checkOutput("bounce_clamp_moving", int'(Moving1), 1);
        doTick(16'h0000, 1'b0);
        checkOutput("bounce_away_posy", int'(PosY1), 7);
        checkOutput("bounce_away_hit", int'(hit1_at_tick), 0);
        checkOutput("bounce_away_dir", int'(Dir1), 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
